coeffs_loader: RTL and testbench
================================

Name: coeffs_loader

Overview:
- Writer-side counterpart of the coefficient memory: a filter coefficient RAM that loads over a valid/ready stream at run time instead of from a file.
- A host sequencer or serial front end pushes `length` words in order, entries 0 to length-1.
- A synchronous read port gives registered read data one cycle after the address, so the FIR datapath can use it as a direct replacement for a file-initialised ROM.
- A small FSM controls the load, with start/abort control and done/loaded status.

Parameters:
- width, 16, coefficient word width in bits.
- length, 8, number of coefficient entries (≥2).
- AW (localparam), $clog2(length)+1, address/count width; it can represent the value `length`.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin a new load sequence.
- abort  in  1  cancel an in-progress load.
- in_valid  in  1  in_data holds a coefficient.
- in_data  in  width  coefficient word.
- in_ready  out  1  loader accepts a word this cycle.
- busy  out  1  load in progress.
- done  out  1  one-cycle pulse after the final word is written.
- loaded  out  1  all `length` entries written since the last start.
- wr_count  out  AW  number of words written in the current or last load.
- address  in  AW  read address.
- out  out  width  registered read data.

Behaviour:
- Reset (rst=1 at posedge):
  - state=IDLE; in_ready=0, busy=0, done=0, loaded=0, wr_count=0, out=0.
  - Memory array is not cleared.
- States: IDLE, LOAD.
- in_ready = (state==LOAD), decoded combinationally from state. busy = in_ready.
- IDLE:
  - start=1 → LOAD next cycle; wr_count<=0, loaded<=0.
  - Other inputs are ignored, including in_valid.
  - start while loaded=1 restarts the load and clears loaded.
- LOAD:
  - A transfer occurs when in_valid && in_ready && !abort: memory[wr_count]<=in_data, wr_count<=wr_count+1.
  - A transfer with wr_count==length-1 → IDLE, wr_count<=length, loaded<=1, done=1 for exactly the next cycle.
  - The state is IDLE in the done cycle, so in_ready=0 in that cycle.
  - in_valid=0 in LOAD: wait indefinitely, no timeout.
- abort=1 in LOAD:
  - → IDLE; no write that cycle, even if in_valid=1.
  - wr_count holds the number of words already written; loaded stays 0; no done pulse.
- Ignored inputs:
  - start in LOAD is ignored.
  - abort in IDLE is ignored.
  - start and abort together in LOAD: abort wins.
- Read port:
  - Every cycle, out <= (address < length) ? memory[address] : 0. Latency is exactly 1 cycle, independent of state.
  - Reads during LOAD are permitted and return current contents, which may be partially loaded.
- Same-cycle write and read of the same address: out returns the OLD contents (read-before-write). The new value is visible on a read issued the following cycle.
- rst during LOAD: behaves as a reset (IDLE, loaded=0, wr_count=0). Entries already written are retained.
- Widths:
  - wr_count never exceeds length; there is no wrap.
  - Address compare is unsigned over AW bits.
- Memory must infer as block/distributed RAM: one write port and one synchronous read port, no reset on the array.

Test Plan (width=16, length=8):
- Basic load and readback:
  - Stimulus: rst, then start, then stream 0x0001..0x0008 with in_valid held high.
  - Required: in_ready high for 8 cycles; done pulses once on the cycle after the 8th transfer; loaded=1; wr_count=8.
  - Then read address 0..7 → out=0x0001..0x0008, each 1 cycle after the address.
- Backpressure gaps:
  - Stimulus: in_valid toggles 1,0,0,1,... during LOAD.
  - Required: only valid cycles write; wr_count increments by exactly 1 per transfer; final memory matches the 8 sent words in order.
- Abort:
  - Stimulus: after 3 transfers (0xAAAA, 0xBBBB, 0xCCCC), assert abort together with in_valid=1 and in_data=0xDDDD.
  - Required: IDLE next cycle; wr_count=3; loaded=0; no done; address 3 still holds its prior value.
- Out-of-range and read-before-write:
  - Stimulus A: address=8 and address=15.
  - Required A: out=0.
  - Stimulus B: during LOAD, set address=2 in the cycle word 2 (0x1234, old value 0x5555) is written.
  - Required B: out=0x5555, then 0x1234 on the next cycle.
- Reset mid-load and restart:
  - Stimulus: rst after 5 transfers, then start and a full load of 0x0100..0x0800.
  - Required: after rst, wr_count=0, loaded=0, out=0, in_ready=0; after the new load, loaded=1 and all 8 entries match the new data.
- Start ignored in LOAD:
  - Stimulus: assert start mid-load at wr_count=4.
  - Required: wr_count continues 4→5 on the next transfer; no counter reset.

Source files
------------

// File: rtl/coeffs_loader.sv
// coeffs_loader: run-time loadable coefficient RAM.
// Stream writer with start/abort control, registered synchronous read port.
module coeffs_loader #(
    parameter int width  = 16,
    parameter int length = 8,
    localparam int AW    = $clog2(length) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic             in_valid,
    input  logic [width-1:0] in_data,
    output logic             in_ready,
    output logic             busy,
    output logic             done,
    output logic             loaded,
    output logic [AW-1:0]    wr_count,
    input  logic [AW-1:0]    address,
    output logic [width-1:0] out
);

    localparam int            IW   = $clog2(length);
    localparam logic [AW-1:0] LEN  = AW'(length);
    localparam logic [AW-1:0] LAST = AW'(length - 1);

    typedef enum logic {
        IDLE,
        LOAD
    } state_t;

    state_t            state_q;
    logic [AW-1:0]     wr_count_q;
    logic [AW-1:0]     wr_count_d;
    logic              loaded_q;
    logic              done_q;
    logic [width-1:0]  out_q;
    logic [width-1:0]  mem_q [length];
    logic              wr_en;

    // abort takes priority over a pending word in the same cycle
    assign wr_en      = (state_q == LOAD) && in_valid && !abort;
    assign wr_count_d = wr_count_q + AW'(1);

    // Load sequencing: state, write counter and status flags
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            wr_count_q <= '0;
            loaded_q   <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q    <= LOAD;
                        wr_count_q <= '0;
                        loaded_q   <= 1'b0;
                    end
                end
                LOAD: begin
                    if (abort) begin
                        state_q <= IDLE;
                    end else if (in_valid) begin
                        wr_count_q <= wr_count_d;
                        if (wr_count_q == LAST) begin
                            state_q  <= IDLE;
                            loaded_q <= 1'b1;
                            done_q   <= 1'b1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Coefficient array write port; contents survive reset
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_count_q[IW-1:0]] <= in_data;
        end
    end

    // Registered read; same-cycle write to the address returns old data
    always_ff @(posedge clk) begin
        if (rst) begin
            out_q <= '0;
        end else if (address < LEN) begin
            out_q <= mem_q[address[IW-1:0]];
        end else begin
            out_q <= '0;
        end
    end

    assign in_ready = (state_q == LOAD);
    assign busy     = (state_q == LOAD);
    assign done     = done_q;
    assign loaded   = loaded_q;
    assign wr_count = wr_count_q;
    assign out      = out_q;

endmodule

// File: tb/tb_coeffs_loader.sv
// tb_coeffs_loader: directed self-checking bench for coeffs_loader.
// Expected read data queued at address issue, compared one cycle later.
module tb_coeffs_loader;

    localparam int W  = 16;
    localparam int L  = 8;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          abort;
    logic          in_valid;
    logic [W-1:0]  in_data;
    logic          in_ready;
    logic          busy;
    logic          done;
    logic          loaded;
    logic [AW-1:0] wr_count;
    logic [AW-1:0] address;
    logic [W-1:0]  out;

    int n_cmp = 0;
    int n_err = 0;
    int exp_cnt = 0;

    logic [W-1:0] ref_mem [L];
    logic [W-1:0] sb [$];

    coeffs_loader #(.width(W), .length(L)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .abort    (abort),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .busy     (busy),
        .done     (done),
        .loaded   (loaded),
        .wr_count (wr_count),
        .address  (address),
        .out      (out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic xfer(input logic [W-1:0] d, input string tag);
        chk({tag, "_ready"}, {31'b0, in_ready}, 32'd1);
        in_valid = 1'b1;
        in_data  = d;
        tick();
        in_valid = 1'b0;
        ref_mem[exp_cnt] = d;
        exp_cnt++;
        chk({tag, "_cnt"}, {28'b0, wr_count}, exp_cnt);
        chk({tag, "_done"}, {31'b0, done}, (exp_cnt == L) ? 32'd1 : 32'd0);
    endtask

    task automatic rd(input logic [AW-1:0] a, input string tag);
        logic [W-1:0] e;
        address = a;
        if (a < L) e = ref_mem[a[2:0]];
        else e = '0;
        sb.push_back(e);
        tick();
        chk(tag, {16'b0, out}, {16'b0, sb.pop_front()});
    endtask

    task automatic begin_load();
        start = 1'b1;
        tick();
        start = 1'b0;
        exp_cnt = 0;
    endtask

    initial begin
        logic [W-1:0] d;
        int sent;
        rst = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        in_valid = 1'b0;
        in_data = '0;
        address = '0;

        // reset state
        tick();
        tick();
        chk("rst_ready", {31'b0, in_ready}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_loaded", {31'b0, loaded}, 32'd0);
        chk("rst_cnt", {28'b0, wr_count}, 32'd0);
        chk("rst_out", {16'b0, out}, 32'd0);
        rst = 1'b0;
        tick();

        // basic load and readback
        begin_load();
        for (int k = 0; k < L; k++) begin
            xfer(16'(k + 1), "t1");
        end
        chk("t1_ready_done_cyc", {31'b0, in_ready}, 32'd0);
        tick();
        chk("t1_done_once", {31'b0, done}, 32'd0);
        chk("t1_loaded", {31'b0, loaded}, 32'd1);
        chk("t1_cnt_final", {28'b0, wr_count}, 32'd8);
        for (int a = 0; a < L; a++) rd(AW'(a), "t1_rd");

        // backpressure gaps: valid on every third cycle
        begin_load();
        sent = 0;
        for (int c = 0; c < 100 && sent < L; c++) begin
            in_valid = (c % 3 == 0);
            in_data = in_valid ? 16'(16'h5553 + sent) : 16'hFFFF;
            tick();
            if (in_valid) begin
                ref_mem[sent] = in_data;
                sent++;
            end
            in_valid = 1'b0;
            chk("t2_cnt", {28'b0, wr_count}, sent);
        end
        chk("t2_sent", sent, 32'd8);
        chk("t2_done", {31'b0, done}, 32'd1);
        tick();
        chk("t2_loaded", {31'b0, loaded}, 32'd1);
        for (int a = 0; a < L; a++) rd(AW'(a), "t2_rd");

        // out of range reads
        rd(4'd8, "t4a_rd8");
        rd(4'd15, "t4a_rd15");

        // read-before-write on addr 2, start ignored at wr_count=4
        begin_load();
        for (int k = 0; k < L; k++) begin
            d = (k == 2) ? 16'h1234 : 16'(16'h0A00 + k);
            address = 4'd2;
            sb.push_back(ref_mem[2]);
            start = (k == 4);
            chk("t4b_ready", {31'b0, in_ready}, 32'd1);
            in_valid = 1'b1;
            in_data = d;
            tick();
            in_valid = 1'b0;
            start = 1'b0;
            ref_mem[k] = d;
            exp_cnt++;
            chk("t4b_rbw", {16'b0, out}, {16'b0, sb.pop_front()});
            chk("t4b_cnt", {28'b0, wr_count}, exp_cnt);
        end
        chk("t4b_done", {31'b0, done}, 32'd1);
        tick();
        chk("t4b_loaded", {31'b0, loaded}, 32'd1);

        // abort after three words
        begin_load();
        chk("t3_loaded_clr", {31'b0, loaded}, 32'd0);
        xfer(16'hAAAA, "t3");
        xfer(16'hBBBB, "t3");
        xfer(16'hCCCC, "t3");
        chk("t3_ready", {31'b0, in_ready}, 32'd1);
        in_valid = 1'b1;
        in_data = 16'hDDDD;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        in_valid = 1'b0;
        chk("t3_idle", {31'b0, in_ready}, 32'd0);
        chk("t3_cnt", {28'b0, wr_count}, 32'd3);
        chk("t3_loaded", {31'b0, loaded}, 32'd0);
        chk("t3_done", {31'b0, done}, 32'd0);
        tick();
        chk("t3_done2", {31'b0, done}, 32'd0);
        for (int a = 0; a < 4; a++) rd(AW'(a), "t3_rd");

        // reset mid-load, then full restart
        begin_load();
        for (int k = 0; k < 5; k++) xfer(16'(16'hEE00 + k), "t6a");
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t6_cnt", {28'b0, wr_count}, 32'd0);
        chk("t6_loaded", {31'b0, loaded}, 32'd0);
        chk("t6_out", {16'b0, out}, 32'd0);
        chk("t6_ready", {31'b0, in_ready}, 32'd0);
        tick();
        begin_load();
        for (int k = 0; k < L; k++) xfer(16'(16'h0100 * (k + 1)), "t6b");
        tick();
        chk("t6_loaded2", {31'b0, loaded}, 32'd1);
        for (int a = 0; a < L; a++) rd(AW'(a), "t6_rd");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
